// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types for the gshare branch predictor.
// Holds the PHT counter encodings, the BTB kind encodings and the BTB field
// widths derived from the table index width.
package gshare_branch_predictor_pkg;

    localparam int unsigned XLEN = 32;

    // 2-bit saturating counter states; taken when >= PHT_WT
    typedef enum logic [1:0] {
        PHT_SNT = 2'd0,
        PHT_WNT = 2'd1,
        PHT_WT  = 2'd2,
        PHT_ST  = 2'd3
    } pht_e;

    localparam pht_e PHT_RESET = PHT_WNT;

    typedef enum logic {
        BTB_BR  = 1'b0,
        BTB_JMP = 1'b1
    } btb_kind_e;

    // Tag covers the PC bits above the index and the 2-bit word offset
    function automatic int unsigned btb_tag_w(input int unsigned idx);
        return XLEN - idx - 2;
    endfunction

    // Saturating counter step; never wraps at either end
    function automatic pht_e pht_next(input pht_e cnt, input logic taken);
        pht_e nxt;
        case (cnt)
            PHT_SNT: nxt = taken ? PHT_WNT : PHT_SNT;
            PHT_WNT: nxt = taken ? PHT_WT  : PHT_SNT;
            PHT_WT:  nxt = taken ? PHT_ST  : PHT_WNT;
            default: nxt = taken ? PHT_ST  : PHT_WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Pipeline <-> branch predictor signal bundle.
// master: fetch/execute side (drives PCs and resolution info).
// slave : predictor (drives prediction, redirect, flushes, counters).
interface gshare_branch_predictor_if;

    logic [31:0] if_pc;
    logic [31:0] pred_next_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_pc;
    logic [31:0] next_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken,
               ex_target, ex_pred_pc,
        input  pred_next_pc, pred_taken, next_pc, flush_if_id, flush_id_ex,
               branch_cnt, mispredict_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken,
               ex_target, ex_pred_pc,
        output pred_next_pc, pred_taken, next_pc, flush_if_id, flush_id_ex,
               branch_cnt, mispredict_cnt
    );

endinterface

// File: rtl/gshare_branch_predictor_bp_table.sv
// BTB + PHT storage.
// Ports: clk, reset (sync clear of valid bits, PHT to WNT);
//   rd_*  : combinational IF read (BTB entry at rd_idx, PHT at rd_pht_idx);
//   btb_w*: synchronous BTB entry write; pht_w*: synchronous saturating PHT step.
module bp_table
    import gshare_branch_predictor_pkg::*;
#(
    parameter  int unsigned ENTRIES = 32,
    localparam int unsigned IDX     = $clog2(ENTRIES),
    localparam int unsigned TAG_W   = btb_tag_w(IDX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX-1:0]   rd_idx,
    input  logic [IDX-1:0]   rd_pht_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_target,
    output btb_kind_e        rd_kind,
    output pht_e             rd_pht,
    input  logic             btb_we,
    input  logic [IDX-1:0]   btb_widx,
    input  logic [TAG_W-1:0] btb_wtag,
    input  logic [XLEN-1:0]  btb_wtarget,
    input  btb_kind_e        btb_wkind,
    input  logic             pht_we,
    input  logic [IDX-1:0]   pht_widx,
    input  logic             pht_wtaken
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        btb_kind_e        kind;
    } btb_data_t;

    logic [ENTRIES-1:0] valid_q, valid_d;
    btb_data_t          btb_q [ENTRIES];
    btb_data_t          btb_d [ENTRIES];
    pht_e               pht_q [ENTRIES];
    pht_e               pht_d [ENTRIES];

    // Write port: next-state of the tables
    always_comb begin
        valid_d = valid_q;
        btb_d   = btb_q;
        pht_d   = pht_q;
        if (btb_we) begin
            valid_d[btb_widx] = 1'b1;
            btb_d[btb_widx]   = '{tag: btb_wtag, target: btb_wtarget, kind: btb_wkind};
        end
        if (pht_we) begin
            pht_d[pht_widx] = pht_next(pht_q[pht_widx], pht_wtaken);
        end
    end

    // Valid bits and counters carry learned state, so they are cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                pht_q[i] <= PHT_RESET;
            end
        end else begin
            valid_q <= valid_d;
            pht_q   <= pht_d;
        end
    end

    // Payload is meaningless while its valid bit is clear
    always_ff @(posedge clk) begin
        btb_q <= btb_d;
    end

    // Read port returns pre-write contents in an update cycle
    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = btb_q[rd_idx].tag;
    assign rd_target = btb_q[rd_idx].target;
    assign rd_kind   = btb_q[rd_idx].kind;
    assign rd_pht    = pht_q[rd_pht_idx];

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare branch predictor and redirect unit.
// Ports: clk, reset (sync, active-high); bp (slave modport) carries the IF
// lookup, EX resolution inputs, next_pc/flush outputs and perf counters.
// Holds the GHR, redirect logic and counters; tables live in bp_table.
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 32,
    parameter int unsigned GHR_BITS    = 4
) (
    input logic                     clk,
    input logic                     reset,
    gshare_branch_predictor_if.slave bp
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = btb_tag_w(IDX);

    logic [IDX-1:0]      if_idx, ex_idx, ghr_ext;
    logic [TAG_W-1:0]    if_tag, ex_tag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [XLEN-1:0]     rd_target;
    btb_kind_e           rd_kind;
    pht_e                rd_pht;
    logic                pred_taken_c;
    logic [XLEN-1:0]     pred_next_pc_c, actual_pc_c, next_pc_c;
    logic                ctl_c, redirect_c, br_upd_c, btb_we_c;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [XLEN-1:0]     branch_cnt_q, branch_cnt_d;
    logic [XLEN-1:0]     mispredict_cnt_q, mispredict_cnt_d;
    logic                unused_pc_lsbs;

    assign if_idx  = bp.if_pc[IDX+1:2];
    assign if_tag  = bp.if_pc[XLEN-1:IDX+2];
    assign ex_idx  = bp.ex_pc[IDX+1:2];
    assign ex_tag  = bp.ex_pc[XLEN-1:IDX+2];
    assign ghr_ext = IDX'(ghr_q);
    assign unused_pc_lsbs = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

    bp_table #(
        .ENTRIES (BTB_ENTRIES)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .rd_idx      (if_idx),
        .rd_pht_idx  (if_idx ^ ghr_ext),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_target   (rd_target),
        .rd_kind     (rd_kind),
        .rd_pht      (rd_pht),
        .btb_we      (btb_we_c),
        .btb_widx    (ex_idx),
        .btb_wtag    (ex_tag),
        .btb_wtarget (bp.ex_target),
        .btb_wkind   (bp.ex_is_jump ? BTB_JMP : BTB_BR),
        .pht_we      (br_upd_c),
        .pht_widx    (ex_idx ^ ghr_ext),
        .pht_wtaken  (bp.ex_taken)
    );

    // IF prediction and EX resolution; a redirect overrides the prediction
    always_comb begin
        pred_taken_c   = rd_valid && (rd_tag == if_tag) &&
                         ((rd_kind == BTB_JMP) || (rd_pht >= PHT_WT));
        pred_next_pc_c = pred_taken_c ? rd_target : bp.if_pc + 32'd4;
        ctl_c          = !reset && bp.ex_valid && (bp.ex_is_branch || bp.ex_is_jump);
        actual_pc_c    = (bp.ex_is_jump || bp.ex_taken) ? bp.ex_target : bp.ex_pc + 32'd4;
        redirect_c     = ctl_c && (actual_pc_c != bp.ex_pred_pc);
        // A jump flag wins if both are set: jumps never touch GHR/PHT
        br_upd_c       = ctl_c && bp.ex_is_branch && !bp.ex_is_jump;
        btb_we_c       = ctl_c && (bp.ex_is_jump || bp.ex_taken);
        if (reset) begin
            next_pc_c = bp.if_pc + 32'd4;
        end else if (redirect_c) begin
            next_pc_c = actual_pc_c;
        end else begin
            next_pc_c = pred_next_pc_c;
        end
    end

    // GHR shift and performance counters
    always_comb begin
        ghr_d            = ghr_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (br_upd_c) begin
            // Truncation drops the oldest bit; also valid for GHR_BITS == 1
            ghr_d = GHR_BITS'({ghr_q, bp.ex_taken});
        end
        if (ctl_c) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (redirect_c) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q            <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            ghr_q            <= ghr_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bp.pred_next_pc   = pred_next_pc_c;
    assign bp.pred_taken     = pred_taken_c;
    assign bp.next_pc        = next_pc_c;
    assign bp.flush_if_id    = redirect_c;
    assign bp.flush_id_ex    = redirect_c;
    assign bp.branch_cnt     = branch_cnt_q;
    assign bp.mispredict_cnt = mispredict_cnt_q;

endmodule
